pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised fetch-PC generator. It is the next generation of the single-width PC register and feeds the IF stage and the BPU. It supports:
- configurable reset vector and fetch-group width;
- N prioritised redirect sources;
- a valid/ready handshake toward IF;
- an epoch tag for squashing wrong-path fetches;
- a halt/boot state machine.

Redirects are never lost under stall.

Parameters:
XLEN, 32, address width.
RESET_VEC, 32'h100, PC loaded on reset.
FETCH_BYTES, 4, bytes per fetch group (power of two, >=4).
NUM_REDIR, 2, redirect sources; index 0 has highest priority.
EPOCH_W, 2, epoch counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
redir_valid  in  NUM_REDIR  per-source redirect request (e.g. [0]=exception/commit, [1]=branch resolve).
redir_addr  in  NUM_REDIR*XLEN  flattened targets; source i occupies [i*XLEN +: XLEN].
pr_valid  in  1  BPU predicts taken for the currently presented group.
pr_addr  in  XLEN  predicted target.
halt  in  1  stop fetching after the current handshake.
fetch_ready  in  1  IF accepts the group (0 = stall).
fetch_valid  out  1  fetch_pc is a live request.
fetch_pc  out  XLEN  fetch address; bits[1:0] are always 0.
fetch_epoch  out  EPOCH_W  epoch tag of the presented request.
halted  out  1  FSM is in HALT.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=BOOT, fetch_pc=RESET_VEC with [1:0] cleared;
  - fetch_valid=0, fetch_epoch=0, halted=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: fetch_valid=0. Next cycle goes to RUN; fetch_pc is unchanged unless a redirect is present.
  - RUN: fetch_valid=1. Fire = fetch_valid && fetch_ready.
  - HALT: fetch_valid=0 and halted=1. Stays in HALT until any redir_valid, then goes to RUN with the target. pr_valid and halt are ignored in HALT.
- Next-PC priority, per cycle, in any state after reset:
  1. Any redir_valid[i]:
     - take the lowest index i;
     - fetch_pc <= redir_addr[i] & ~3;
     - fetch_epoch <= fetch_epoch+1, wrapping mod 2^EPOCH_W;
     - state <= RUN.
     Accepted regardless of fetch_ready. The request presented in that cycle is squashed: IF distinguishes it by the old epoch. fetch_valid is 1 on the following cycle (latency 1).
  2. Else if fire && pr_valid: fetch_pc <= pr_addr & ~3. Epoch is unchanged.
  3. Else if fire: fetch_pc <= (fetch_pc & ~(FETCH_BYTES-1)) + FETCH_BYTES. This aligns to the next group and wraps modulo 2^XLEN.
  4. Else (stall): fetch_pc, fetch_epoch and fetch_valid are held stable.
- halt while RUN:
  - if fire (or redirect) occurs in the same cycle, the PC update per the priority rules is still applied, then state <= HALT;
  - with no fire and no redirect, state <= HALT immediately and fetch_pc is held.
  - A redirect coincident with halt: the PC and epoch are updated, and the state goes to HALT, not RUN.
- Redirect during BOOT: the target is loaded and the epoch increments; the next state is RUN.
- pr_valid without fire is ignored; the BPU re-presents it.
- Invariant: while fetch_valid && !fetch_ready and no redirect is present, fetch_pc and fetch_epoch must not change.

Decomposition:
- Package pc_gen_pkg holds:
  - state enum {BOOT, RUN, HALT};
  - default XLEN/RESET_VEC constants;
  - an align-mask helper function.
- One sub-module, redir_arb: a combinational fixed-priority select. Inputs are redir_valid/redir_addr; outputs are any_redir and sel_addr.
- The rest is a single always_ff with async reset plus next-state logic.

Test Plan:
- Reset, then release: cycle 0 fetch_valid=0 and fetch_pc=0x100. Next cycle fetch_valid=1 and fetch_pc=0x100. With fetch_ready=1 the sequence is 0x100, 0x104, 0x108. With FETCH_BYTES=8 and a redirect to 0x204, the next PC is 0x208, then 0x210.
- Stall 3 cycles (fetch_ready=0) at PC 0x110 → fetch_pc stays 0x110 and the epoch is unchanged. redir_valid[1]=1 to 0x400 during the stall → next cycle fetch_pc=0x400, epoch 0→1, fetch_valid=1.
- Same cycle: redir_valid=2'b11 (addresses 0x800 and 0x900) plus pr_valid to 0x500 → fetch_pc=0x800 and epoch+1. pr_valid alone with fire to 0x502 → fetch_pc=0x500.
- Four back-to-back redirects from epoch 2 (EPOCH_W=2) → epoch sequence 3, 0, 1, 2.
- halt asserted while fire at 0x120 → next cycle fetch_pc=0x124, fetch_valid=0, halted=1. It holds for 5 cycles ignoring pr_valid. A redirect to 0x300 → RUN, fetch_pc=0x300, fetch_valid=1.
- Assert rst mid-stream at PC 0x1F0 between clock edges → fetch_valid=0 and fetch_pc=0x100 immediately, without waiting for a clock edge; the epoch is cleared to 0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and helpers for the fetch-PC generator.
//   - pc_state_e    : boot/run/halt state encoding
//   - DEF_XLEN      : default address width
//   - DEF_RESET_VEC : default reset vector
//   - align_mask()  : clears the low log2(bytes) address bits
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int unsigned DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0100;

  // Mask that clears the low log2(bytes) bits; bytes must be a power of two.
  // Callers truncate the result to their own address width.
  function automatic logic [63:0] align_mask(input int unsigned bytes);
    align_mask = ~(64'(bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_gen_redir_arb.sv
// pc_gen_redir_arb: combinational fixed-priority redirect selector.
// Ports:
//   redir_valid : per-source request, index 0 wins
//   redir_addr  : flattened targets, source i at [i*XLEN +: XLEN]
//   any_redir   : at least one source is requesting
//   sel_addr    : target of the lowest-index requesting source (0 if none)
module pc_gen_redir_arb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned NUM_REDIR = 2
) (
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_addr,
  output logic                      any_redir,
  output logic [XLEN-1:0]           sel_addr
);

  logic found_s;

  // Scan from index 0 upward; the first requesting source locks the selection.
  always_comb begin
    any_redir = |redir_valid;
    sel_addr  = '0;
    found_s   = 1'b0;
    for (int i = 0; i < int'(NUM_REDIR); i++) begin
      if (redir_valid[i] && !found_s) begin
        sel_addr = redir_addr[i*XLEN +: XLEN];
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-PC generator feeding the IF stage and the BPU.
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   redir_valid    : per-source redirect request, index 0 highest priority
//   redir_addr     : flattened redirect targets
//   pr_valid/addr  : BPU taken prediction for the presented group
//   halt           : stop fetching after the current handshake
//   fetch_ready    : IF accepts the presented group
//   fetch_valid    : fetch_pc is a live request
//   fetch_pc       : fetch address, always word aligned
//   fetch_epoch    : epoch tag, bumped on every redirect
//   halted         : generator is parked in HALT
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
  parameter int unsigned     FETCH_BYTES = 4,
  parameter int unsigned     NUM_REDIR   = 2,
  parameter int unsigned     EPOCH_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_addr,
  input  logic                      pr_valid,
  input  logic [XLEN-1:0]           pr_addr,
  input  logic                      halt,
  input  logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [XLEN-1:0]           fetch_pc,
  output logic [EPOCH_W-1:0]        fetch_epoch,
  output logic                      halted
);

  localparam logic [XLEN-1:0] WORD_MASK = XLEN'(align_mask(4));
  localparam logic [XLEN-1:0] GRP_MASK  = XLEN'(align_mask(FETCH_BYTES));
  localparam logic [XLEN-1:0] GRP_STEP  = XLEN'(FETCH_BYTES);

  pc_state_e          state_r, state_s;
  logic [XLEN-1:0]    pc_r, pc_s;
  logic [EPOCH_W-1:0] epoch_r, epoch_s;
  logic               valid_r, halted_r;
  logic               any_redir_s;
  logic [XLEN-1:0]    sel_addr_s;
  logic               fire_s;

  pc_gen_redir_arb #(
    .XLEN      (XLEN),
    .NUM_REDIR (NUM_REDIR)
  ) u_redir_arb (
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .any_redir   (any_redir_s),
    .sel_addr    (sel_addr_s)
  );

  // Next-state / next-PC selection: redirect > predicted fire > sequential fire > hold.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    epoch_s = epoch_r;
    fire_s  = valid_r && fetch_ready;
    if (any_redir_s) begin
      // Redirect wins regardless of stall; the old epoch marks the squashed request.
      pc_s    = sel_addr_s & WORD_MASK;
      epoch_s = epoch_r + EPOCH_W'(1);
      if (state_r == RUN && halt) begin
        state_s = HALT;
      end else begin
        state_s = RUN;
      end
    end else begin
      case (state_r)
        BOOT: begin
          state_s = RUN;
        end
        RUN: begin
          if (fire_s && pr_valid) begin
            pc_s = pr_addr & WORD_MASK;
          end else if (fire_s) begin
            pc_s = (pc_r & GRP_MASK) + GRP_STEP;
          end else begin
            pc_s = pc_r;
          end
          if (halt) begin
            state_s = HALT;
          end else begin
            state_s = RUN;
          end
        end
        HALT: begin
          state_s = HALT;
        end
        default: begin
          state_s = BOOT;
        end
      endcase
    end
  end

  // State, PC, epoch and the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= BOOT;
      pc_r     <= RESET_VEC & WORD_MASK;
      epoch_r  <= '0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      epoch_r  <= epoch_s;
      valid_r  <= (state_s == RUN);
      halted_r <= (state_s == HALT);
    end
  end

  assign fetch_valid = valid_r;
  assign fetch_pc    = pc_r;
  assign fetch_epoch = epoch_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen (FETCH_BYTES=4 and FETCH_BYTES=8 instances).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  redir_valid;
  logic [63:0] redir_addr;
  logic        pr_valid;
  logic [31:0] pr_addr;
  logic        halt;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [1:0]  fetch_epoch;
  logic        halted;

  logic        rst8;
  logic [1:0]  redir_valid8;
  logic [63:0] redir_addr8;
  logic        fetch_ready8;
  logic        pr_valid8;
  logic [31:0] pr_addr8;
  logic        halt8;
  logic        fetch_valid8;
  logic [31:0] fetch_pc8;
  logic [1:0]  fetch_epoch8;
  logic        halted8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .FETCH_BYTES(4), .NUM_REDIR(2), .EPOCH_W(2)) dut (
    .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_addr(redir_addr),
    .pr_valid(pr_valid), .pr_addr(pr_addr), .halt(halt), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_epoch(fetch_epoch), .halted(halted)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .FETCH_BYTES(8), .NUM_REDIR(2), .EPOCH_W(2)) dut8 (
    .clk(clk), .rst(rst8), .redir_valid(redir_valid8), .redir_addr(redir_addr8),
    .pr_valid(pr_valid8), .pr_addr(pr_addr8), .halt(halt8), .fetch_ready(fetch_ready8),
    .fetch_valid(fetch_valid8), .fetch_pc(fetch_pc8), .fetch_epoch(fetch_epoch8), .halted(halted8)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic v,
                           input logic [1:0] ep, input logic h);
    check({tag, ".pc"},     fetch_pc,           pc);
    check({tag, ".valid"},  32'(fetch_valid),   32'(v));
    check({tag, ".epoch"},  32'(fetch_epoch),   32'(ep));
    check({tag, ".halted"}, 32'(halted),        32'(h));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    redir_valid = v;
    redir_addr  = {a1, a0};
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b0; pr_valid = 1'b0; pr_addr = 32'h0; halt = 1'b0;
    set_redir(2'b00, 32'h0, 32'h0);
    rst8 = 1'b1; redir_valid8 = 2'b00; redir_addr8 = 64'h0; fetch_ready8 = 1'b0;
    pr_valid8 = 1'b0; pr_addr8 = 32'h0; halt8 = 1'b0;
    #3;
    check_all("in_reset", 32'h100, 1'b0, 2'd0, 1'b0);
    step(); step();
    rst = 1'b0;
    check_all("boot", 32'h100, 1'b0, 2'd0, 1'b0);

    // Sequential fetch
    fetch_ready = 1'b1;
    step(); check_all("run0", 32'h100, 1'b1, 2'd0, 1'b0);
    step(); check_all("seq1", 32'h104, 1'b1, 2'd0, 1'b0);
    step(); check_all("seq2", 32'h108, 1'b1, 2'd0, 1'b0);
    step(); check("seq3", fetch_pc, 32'h10C);
    step(); check("seq4", fetch_pc, 32'h110);

    // Stall holds PC and epoch
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_all("stall", 32'h110, 1'b1, 2'd0, 1'b0);
    end
    set_redir(2'b10, 32'h0, 32'h400);
    step(); check_all("redir_stall", 32'h400, 1'b1, 2'd1, 1'b0);

    // Priority: source 0 beats source 1 beats prediction
    set_redir(2'b11, 32'h800, 32'h900);
    pr_valid = 1'b1; pr_addr = 32'h500; fetch_ready = 1'b1;
    step(); check_all("prio", 32'h800, 1'b1, 2'd2, 1'b0);
    set_redir(2'b00, 32'h0, 32'h0);
    pr_addr = 32'h502;
    step(); check_all("pred", 32'h500, 1'b1, 2'd2, 1'b0);
    pr_valid = 1'b0;

    // Back-to-back redirects wrap the epoch; first target is unaligned
    set_redir(2'b01, 32'h603, 32'h0);
    step(); check_all("b2b0", 32'h600, 1'b1, 2'd3, 1'b0);
    set_redir(2'b01, 32'h610, 32'h0);
    step(); check_all("b2b1", 32'h610, 1'b1, 2'd0, 1'b0);
    set_redir(2'b01, 32'h620, 32'h0);
    step(); check_all("b2b2", 32'h620, 1'b1, 2'd1, 1'b0);
    set_redir(2'b01, 32'h630, 32'h0);
    step(); check_all("b2b3", 32'h630, 1'b1, 2'd2, 1'b0);
    set_redir(2'b00, 32'h0, 32'h0);

    // Prediction without fire is ignored
    fetch_ready = 1'b0; pr_valid = 1'b1; pr_addr = 32'h700;
    step(); check_all("pred_nofire", 32'h630, 1'b1, 2'd2, 1'b0);
    pr_valid = 1'b0;

    // Halt with fire at 0x120
    set_redir(2'b01, 32'h120, 32'h0);
    step(); check_all("to120", 32'h120, 1'b1, 2'd3, 1'b0);
    set_redir(2'b00, 32'h0, 32'h0);
    fetch_ready = 1'b1; halt = 1'b1;
    step(); check_all("halt_fire", 32'h124, 1'b0, 2'd3, 1'b1);
    pr_valid = 1'b1; pr_addr = 32'h700;
    for (int i = 0; i < 5; i++) begin
      step(); check_all("halt_hold", 32'h124, 1'b0, 2'd3, 1'b1);
    end
    pr_valid = 1'b0; halt = 1'b0;
    set_redir(2'b01, 32'h300, 32'h0);
    step(); check_all("halt_exit", 32'h300, 1'b1, 2'd0, 1'b0);
    set_redir(2'b00, 32'h0, 32'h0);

    // Halt without fire holds PC
    fetch_ready = 1'b0; halt = 1'b1;
    step(); check_all("halt_nofire", 32'h300, 1'b0, 2'd0, 1'b1);
    // In HALT, halt is ignored and a redirect resumes RUN
    set_redir(2'b10, 32'h0, 32'h340);
    step(); check_all("halt_redir", 32'h340, 1'b1, 2'd1, 1'b0);
    // Redirect coincident with halt while RUN goes to HALT
    set_redir(2'b01, 32'h380, 32'h0);
    step(); check_all("redir_halt", 32'h380, 1'b0, 2'd2, 1'b1);
    halt = 1'b0;
    set_redir(2'b01, 32'h1E0, 32'h0);
    step(); check_all("to1E0", 32'h1E0, 1'b1, 2'd3, 1'b0);
    set_redir(2'b00, 32'h0, 32'h0);
    fetch_ready = 1'b1;
    step(); step(); step(); step();
    check("at1F0", fetch_pc, 32'h1F0);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1 check_all("async_rst", 32'h100, 1'b0, 2'd0, 1'b0);
    #1 rst = 1'b0;
    // Redirect during BOOT
    set_redir(2'b01, 32'h440, 32'h0);
    step(); check_all("boot_redir", 32'h440, 1'b1, 2'd1, 1'b0);

    // Address wrap on sequential fetch
    set_redir(2'b01, 32'hFFFF_FFFC, 32'h0);
    step(); check("wrap0", fetch_pc, 32'hFFFF_FFFC);
    set_redir(2'b00, 32'h0, 32'h0);
    step(); check_all("wrap1", 32'h0, 1'b1, 2'd2, 1'b0);

    // FETCH_BYTES = 8 instance
    rst8 = 1'b0;
    check("fb8_boot_pc", fetch_pc8, 32'h100);
    step();
    check("fb8_run", 32'(fetch_valid8), 32'd1);
    redir_valid8 = 2'b01; redir_addr8 = {32'h0, 32'h204}; fetch_ready8 = 1'b1;
    step(); check("fb8_redir", fetch_pc8, 32'h204);
    check("fb8_epoch", 32'(fetch_epoch8), 32'd1);
    redir_valid8 = 2'b00;
    step(); check("fb8_seq1", fetch_pc8, 32'h208);
    step(); check("fb8_seq2", fetch_pc8, 32'h210);
    check("fb8_halted", 32'(halted8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
